buff_rd_ctrl: RTL

Read-side sequencer for the column data buffer's async FIFO, running entirely in the rd_clk domain. Pulls words from the FIFO read port and presents them to a PE through a valid/ready handshake. Groups words into kernel windows of kernel_size*kernel_size elements and flags the last element of each window. Runs a programmed number of windows per start, then reports done.

---
 rtl/buff_rd_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/buff_rd_ctrl.sv
// Read-side sequencer: pulls words from the async FIFO read port through a 2-entry
// skid buffer and streams them to a PE in kernel windows of K*K elements.
module buff_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            kernel_size,
    input  logic [15:0]           num_windows,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  pe_valid,
    input  logic                  pe_ready,
    output logic [DATA_WIDTH-1:0] pe_data,
    output logic                  pe_last,
    output logic [15:0]           win_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [15:0]           kk_q, kk_d;
    logic [15:0]           nwin_q, nwin_d;
    logic [31:0]           total_q, total_d;
    logic [31:0]           issued_q, issued_d;
    logic [15:0]           elem_q, elem_d;
    logic [15:0]           win_q, win_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [DATA_WIDTH-1:0] skid_mem [0:SKID_DEPTH-1];

    logic        pop;
    logic        is_last;
    logic        final_hs;
    logic [2:0]  occ;
    logic [15:0] kk_new;
    logic [31:0] total_new;

    assign pe_valid   = (cnt_q != 2'd0);
    assign pe_data    = pe_valid ? skid_mem[rd_ptr_q] : '0;
    assign pop        = pe_valid && pe_ready;
    assign is_last    = pe_valid && (elem_q == kk_q - 16'd1);
    assign pe_last    = is_last;
    assign final_hs   = pop && is_last && (win_q == nwin_q - 16'd1);
    assign win_idx    = win_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign cfg_err    = cfg_err_q;
    assign kk_new     = 16'(kernel_size) * 16'(kernel_size);
    assign total_new  = 32'(kk_new) * 32'(num_windows);

    // Occupancy counts reads still in flight so the skid can never overflow.
    assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign fifo_rd_en = (state_q == S_RUN) && !abort && !fifo_empty &&
                        (issued_q < total_q) &&
                        (occ < 3'(SKID_DEPTH) + {2'b00, pop});

    always_comb begin
        state_d    = state_q;
        kk_d       = kk_q;
        nwin_d     = nwin_q;
        total_d    = total_q;
        issued_d   = issued_q;
        elem_d     = elem_q;
        win_d      = win_q;
        inflight_d = inflight_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cfg_err_d  = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            issued_d   = '0;
            elem_d     = '0;
            win_d      = '0;
            inflight_d = 1'b0;
            cnt_d      = '0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (kernel_size == 8'd0 || num_windows == 16'd0) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            kk_d     = kk_new;
                            nwin_d   = num_windows;
                            total_d  = total_new;
                            issued_d = '0;
                            elem_d   = '0;
                            win_d    = '0;
                            state_d  = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (final_hs)
                        state_d = S_DONE;
                    else if (issued_q == total_q)
                        state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (final_hs)
                        state_d = S_DONE;
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if (fifo_rd_en)
                issued_d = issued_q + 32'd1;
            inflight_d = fifo_rd_en;

            if (inflight_q)
                wr_ptr_d = ~wr_ptr_q;
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

            // Window index holds at the final window instead of rolling over.
            if (pop) begin
                if (is_last) begin
                    elem_d = '0;
                    if (win_q != nwin_q - 16'd1)
                        win_d = win_q + 16'd1;
                end else begin
                    elem_d = elem_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            kk_q       <= '0;
            nwin_q     <= '0;
            total_q    <= '0;
            issued_q   <= '0;
            elem_q     <= '0;
            win_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kk_q       <= kk_d;
            nwin_q     <= nwin_d;
            total_q    <= total_d;
            issued_q   <= issued_d;
            elem_q     <= elem_d;
            win_q      <= win_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Skid payload needs no reset: pe_data is masked while the skid is empty.
    always_ff @(posedge rd_clk) begin
        if (inflight_q && !abort)
            skid_mem[wr_ptr_q] <= fifo_rdata;
    end

endmodule
